// File: rtl/ahb_slave_arbiter.sv
// Round-robin arbiter sharing one AHB slave port among MASTER_NUM masters.
// Supports locked sequences, a bounded hold count with forced hand-over, and hready freeze.
module ahb_slave_arbiter #(
    parameter int unsigned MASTER_NUM = 4,
    parameter int unsigned MAX_HOLD   = 8
) (
    input  logic                              hclk,
    input  logic                              hreset,
    input  logic [MASTER_NUM-1:0]             hreq,
    input  logic [MASTER_NUM-1:0]             hlock,
    input  logic [2*MASTER_NUM-1:0]           htrans,
    input  logic                              hready,
    output logic [MASTER_NUM-1:0]             hgrant,
    output logic [$clog2(MASTER_NUM)-1:0]     hmaster,
    output logic [$clog2(MASTER_NUM)-1:0]     hmaster_data,
    output logic                              hsel
);

    localparam int unsigned IDX_W = $clog2(MASTER_NUM);
    localparam int unsigned CNT_W = 8;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_OWNED = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [MASTER_NUM-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]        master_q, master_d;
    logic [IDX_W-1:0]        master_data_q, master_data_d;
    logic [IDX_W-1:0]        last_q, last_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic [1:0]              own_trans;
    logic                    own_req;
    logic                    own_lock;
    logic                    owned;
    logic                    accepted;
    logic                    others_req;
    logic                    forced;
    logic                    release_c;
    logic [MASTER_NUM-1:0]   cand;
    logic                    win_found;
    logic [IDX_W-1:0]        win_idx;

    // Address-phase owner's view of the bus
    always_comb begin
        own_trans  = htrans[{master_q, 1'b0} +: 2];
        own_req    = hreq[master_q];
        own_lock   = hlock[master_q];
        owned      = (state_q == ARB_OWNED);
        accepted   = hready && owned && own_trans[1];
        cand       = hreq & ~grant_q;
        others_req = |cand;
        // Hand-over only at a burst boundary (NONSEQ), never mid-burst
        forced     = (cnt_q >= CNT_W'(MAX_HOLD)) && others_req && (own_trans == TRANS_NONSEQ);
        release_c  = !own_lock && (!own_req || (own_trans == TRANS_IDLE) || forced);
    end

    // Round-robin search starting just after the last owner; excludes the current owner
    always_comb begin
        logic [IDX_W-1:0] idx;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = '0;
        for (int unsigned i = 1; i <= MASTER_NUM; i++) begin
            idx = IDX_W'((int'(last_q) + int'(i)) % int'(MASTER_NUM));
            if (!win_found && cand[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
    end

    always_comb begin
        logic do_arb;
        state_d       = state_q;
        grant_d       = grant_q;
        master_d      = master_q;
        master_data_d = master_data_q;
        last_d        = last_q;
        cnt_d         = cnt_q;
        do_arb        = 1'b0;

        if (hready) begin
            master_data_d = master_q;
            case (state_q)
                ARB_IDLE: begin
                    do_arb = |hreq;
                end
                ARB_OWNED: begin
                    if (release_c) begin
                        do_arb = 1'b1;
                    end else if (accepted && (cnt_q < CNT_W'(MAX_HOLD))) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    do_arb = 1'b0;
                end
            endcase

            if (do_arb) begin
                cnt_d = '0;
                if (win_found) begin
                    state_d  = ARB_OWNED;
                    grant_d  = MASTER_NUM'(1) << win_idx;
                    master_d = win_idx;
                    last_d   = win_idx;
                end else begin
                    state_d  = ARB_IDLE;
                    grant_d  = '0;
                    master_d = '0;
                end
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q       <= ARB_IDLE;
            grant_q       <= '0;
            master_q      <= '0;
            master_data_q <= '0;
            last_q        <= IDX_W'(MASTER_NUM - 1);
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            master_q      <= master_d;
            master_data_q <= master_data_d;
            last_q        <= last_d;
            cnt_q         <= cnt_d;
        end
    end

    assign hgrant       = grant_q;
    assign hmaster      = master_q;
    assign hmaster_data = master_data_q;
    assign hsel         = owned && own_trans[1];

endmodule
